// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit (+ mem_access_pkg)
// Purpose  : Executes one decoded MEM_* load/store per start over a
//            req/gnt/rvalid data bus; builds byte enables and lane-replicated
//            store data, extends load data, reports misaligned and access
//            faults to the trap logic.
// Revision : 1.0 - initial release
// ============================================================================

package mem_access_pkg;
  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_e;
endpackage

module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  mem_access_pkg::mem_op_e inst_type_i,
  input  logic [31:0]             addr_i,
  input  logic [31:0]             wdata_i,
  output logic [31:0]             rdata_o,
  output logic                    done_o,
  output logic                    busy_o,
  output logic                    exc_o,
  output logic [31:0]             exc_cause_o,
  output logic [31:0]             exc_addr_o,
  output logic                    bus_req_o,
  output logic                    bus_we_o,
  output logic [31:0]             bus_addr_o,
  output logic [3:0]              bus_be_o,
  output logic [31:0]             bus_wdata_o,
  input  logic                    bus_gnt_i,
  input  logic                    bus_rvalid_i,
  input  logic [31:0]             bus_rdata_i,
  input  logic                    bus_err_i
);
  import mem_access_pkg::*;

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  // Last count value before the limit is reached on the following edge.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  mem_op_e          type_q, type_d;
  logic [1:0]       off_q, off_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             store_q, store_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             exc_q, exc_d;
  logic [2:0]       cause_q, cause_d;
  logic [31:0]      exc_addr_q, exc_addr_d;
  logic             req_q, req_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [3:0]       bus_be_q, bus_be_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;

  logic        w_is_store, w_is_byte, w_is_half, w_is_word, w_misal;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_shifted, w_load;

  // Decode the incoming op: access size, alignment, byte lanes, store data.
  always_comb begin
    w_is_store = (inst_type_i == MEM_SB) || (inst_type_i == MEM_SH) || (inst_type_i == MEM_SW);
    w_is_byte  = (inst_type_i == MEM_LB) || (inst_type_i == MEM_LBU) || (inst_type_i == MEM_SB);
    w_is_half  = (inst_type_i == MEM_LH) || (inst_type_i == MEM_LHU) || (inst_type_i == MEM_SH);
    w_is_word  = (inst_type_i == MEM_LW) || (inst_type_i == MEM_SW);
    w_misal    = (w_is_half && addr_i[0]) || (w_is_word && (addr_i[1:0] != 2'b00));
    if (w_is_byte)      w_be = 4'b0001 << addr_i[1:0];
    else if (w_is_half) w_be = 4'b0011 << addr_i[1:0];
    else                w_be = 4'b1111;
    if (w_is_byte)      w_wdata = {4{wdata_i[7:0]}};
    else if (w_is_half) w_wdata = {2{wdata_i[15:0]}};
    else                w_wdata = wdata_i;
  end

  // Align the returned word to the addressed lane and extend to 32 bits.
  always_comb begin
    w_shifted = bus_rdata_i >> {off_q, 3'b000};
    case (type_q)
      MEM_LB:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
      MEM_LH:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
      MEM_LBU: w_load = {24'd0, w_shifted[7:0]};
      MEM_LHU: w_load = {16'd0, w_shifted[15:0]};
      default: w_load = w_shifted;
    endcase
  end

  // Next-state logic: accept, bus handshake, timeout and fault capture.
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    off_d       = off_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    store_d     = store_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    exc_d       = exc_q;
    cause_d     = cause_q;
    exc_addr_d  = exc_addr_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i && (inst_type_i != MEM_NOP)) begin
          exc_d   = 1'b0;
          cause_d = 3'd0;
          type_d  = inst_type_i;
          off_d   = addr_i[1:0];
          addr_d  = addr_i;
          store_d = w_is_store;
          cnt_d   = '0;
          if (w_misal) begin
            // Misaligned ops never reach the bus.
            exc_d      = 1'b1;
            cause_d    = w_is_store ? 3'd6 : 3'd4;
            exc_addr_d = addr_i;
            done_d     = 1'b1;
            state_d    = ST_DONE;
          end else begin
            bus_addr_d  = {addr_i[31:2], 2'b00};
            bus_be_d    = w_be;
            bus_wdata_d = w_wdata;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          exc_d      = 1'b1;
          cause_d    = store_q ? 3'd7 : 3'd5;
          exc_addr_d = addr_q;
          done_d     = 1'b1;
          state_d    = ST_DONE;
        end else if (bus_gnt_i) begin
          // A response is never expected in the grant cycle, so rvalid is ignored here.
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_rvalid_i) begin
          if (bus_err_i) begin
            exc_d      = 1'b1;
            cause_d    = store_q ? 3'd7 : 3'd5;
            exc_addr_d = addr_q;
          end else if (!store_q) begin
            rdata_d = w_load;
          end
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          exc_d      = 1'b1;
          cause_d    = store_q ? 3'd7 : 3'd5;
          exc_addr_d = addr_q;
          done_d     = 1'b1;
          state_d    = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_REQ) || (state_d == ST_WAIT);
    req_d  = (state_d == ST_REQ);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      type_q      <= MEM_NOP;
      off_q       <= 2'd0;
      addr_q      <= 32'd0;
      cnt_q       <= '0;
      store_q     <= 1'b0;
      rdata_q     <= 32'd0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      exc_q       <= 1'b0;
      cause_q     <= 3'd0;
      exc_addr_q  <= 32'd0;
      req_q       <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_be_q    <= 4'd0;
      bus_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      off_q       <= off_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      store_q     <= store_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      exc_q       <= exc_d;
      cause_q     <= cause_d;
      exc_addr_q  <= exc_addr_d;
      req_q       <= req_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign rdata_o     = rdata_q;
  assign done_o      = done_q;
  assign busy_o      = busy_q;
  assign exc_o       = exc_q;
  assign exc_cause_o = {29'd0, cause_q};
  assign exc_addr_o  = exc_addr_q;
  assign bus_req_o   = req_q;
  assign bus_we_o    = store_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_be_o    = bus_be_q;
  assign bus_wdata_o = bus_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit; expected completions
//            are queued at issue time and compared on each done_o pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i, start_i;
  mem_op_e     inst_type_i;
  logic [31:0] addr_i, wdata_i;
  logic [31:0] rdata_o, exc_cause_o, exc_addr_o, bus_addr_o, bus_wdata_o;
  logic        done_o, busy_o, exc_o, bus_req_o, bus_we_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i, bus_rvalid_i, bus_err_i;
  logic [31:0] bus_rdata_i;

  typedef struct {
    logic        exc;
    logic [31:0] cause;
    logic [31:0] addr;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_rdata = 32'd0;

  mem_access_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .inst_type_i(inst_type_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .done_o(done_o),
    .busy_o(busy_o), .exc_o(exc_o), .exc_cause_o(exc_cause_o),
    .exc_addr_o(exc_addr_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic exc, input logic [31:0] cause, input logic [31:0] addr);
    exp_t e;
    e.exc = exc; e.cause = cause; e.addr = addr; e.rdata = model_rdata;
    sb.push_back(e);
  endtask

  // Present one op for a single cycle; returns one cycle after acceptance.
  task automatic issue(input mem_op_e op, input logic [31:0] a, input logic [31:0] wd);
    start_i = 1'b1; inst_type_i = op; addr_i = a; wdata_i = wd;
    tick();
    start_i = 1'b0; inst_type_i = MEM_NOP;
  endtask

  // Act as the bus: grant after gdly cycles, respond in the next cycle.
  task automatic bus_resp(input int gdly, input logic err, input logic [31:0] rd,
                          input logic [31:0] e_addr, input logic [3:0] e_be,
                          input logic [31:0] e_wd, input logic e_we);
    for (int i = 0; i <= gdly; i++) begin
      check("req_high", 32'(bus_req_o), 32'd1);
      check("bus_addr", bus_addr_o, e_addr);
      check("bus_be", 32'(bus_be_o), 32'(e_be));
      check("bus_wdata", bus_wdata_o, e_wd);
      check("bus_we", 32'(bus_we_o), 32'(e_we));
      if (i == gdly) bus_gnt_i = 1'b1;
      tick();
    end
    bus_gnt_i = 1'b0;
    check("req_drop", 32'(bus_req_o), 32'd0);
    check("busy_wait", 32'(busy_o), 32'd1);
    bus_rvalid_i = 1'b1; bus_err_i = err; bus_rdata_i = rd;
    tick();
    bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
    check("done_after_rvalid", 32'(done_o), 32'd1);
    tick();
    check("done_one_cycle", 32'(done_o), 32'd0);
  endtask

  // Scoreboard: every done_o pulse must match the oldest queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (done_o) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'(done_o), 32'd0);
      end else begin
        e = sb.pop_front();
        check("done_exc", 32'(exc_o), 32'(e.exc));
        check("done_cause", exc_cause_o, e.cause);
        if (e.exc) check("done_exc_addr", exc_addr_o, e.addr);
        check("done_rdata", rdata_o, e.rdata);
      end
    end
  end

  initial begin
    rst_i = 1'b1; start_i = 1'b0; inst_type_i = MEM_NOP; addr_i = 32'd0; wdata_i = 32'd0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = 32'd0;
    repeat (3) tick();
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_req", 32'(bus_req_o), 32'd0);
    check("rst_exc", 32'(exc_o), 32'd0);
    check("rst_be", 32'(bus_be_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // NOP start is ignored
    issue(MEM_NOP, 32'h10, 32'd0);
    check("nop_busy", 32'(busy_o), 32'd0);
    tick();

    // LB at 0x1003, byte 0x80 sign-extends
    model_rdata = 32'hFFFF_FF80; push(1'b0, 32'd0, 32'd0);
    issue(MEM_LB, 32'h0000_1003, 32'd0);
    bus_resp(0, 1'b0, 32'h80AA_BBCC, 32'h0000_1000, 4'b1000, 32'd0, 1'b0);

    // LBU same data zero-extends
    model_rdata = 32'h0000_0080; push(1'b0, 32'd0, 32'd0);
    issue(MEM_LBU, 32'h0000_1003, 32'd0);
    bus_resp(0, 1'b0, 32'h80AA_BBCC, 32'h0000_1000, 4'b1000, 32'd0, 1'b0);

    // SH at 0x0102: upper half lanes, replicated data, rdata held
    push(1'b0, 32'd0, 32'd0);
    issue(MEM_SH, 32'h0000_0102, 32'h0000_1234);
    bus_resp(0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0100, 4'b1100, 32'h1234_1234, 1'b1);

    // Misaligned LW: no bus request, cause 4
    push(1'b1, 32'd4, 32'h0000_0101);
    issue(MEM_LW, 32'h0000_0101, 32'd0);
    check("misal_lw_done", 32'(done_o), 32'd1);
    check("misal_lw_req", 32'(bus_req_o), 32'd0);
    tick();
    check("misal_lw_req2", 32'(bus_req_o), 32'd0);

    // Misaligned SW: cause 6
    push(1'b1, 32'd6, 32'h0000_0102);
    issue(MEM_SW, 32'h0000_0102, 32'h5555_AAAA);
    check("misal_sw_req", 32'(bus_req_o), 32'd0);
    tick();

    // SW with grant delayed 3 cycles and bus error: cause 7
    push(1'b1, 32'd7, 32'h0000_0200);
    issue(MEM_SW, 32'h0000_0200, 32'hDEAD_BEEF);
    bus_resp(3, 1'b1, 32'd0, 32'h0000_0200, 4'b1111, 32'hDEAD_BEEF, 1'b1);

    // Timeout with no grant: done in cycle 9 after start, cause 5
    push(1'b1, 32'd5, 32'h0000_0040);
    issue(MEM_LB, 32'h0000_0040, 32'd0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("to_not_done", 32'(done_o), 32'd0);
    end
    tick();
    check("to_done", 32'(done_o), 32'd1);
    check("to_req_drop", 32'(bus_req_o), 32'd0);
    tick();
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h1122_3344;
    tick();
    bus_rvalid_i = 1'b0;
    repeat (3) tick();
    check("late_rvalid_busy", 32'(busy_o), 32'd0);
    check("late_rvalid_rdata", rdata_o, 32'h0000_0080);

    // Reset while waiting for the response: no done, bus idle
    issue(MEM_LW, 32'h0000_0008, 32'd0);
    bus_gnt_i = 1'b1;
    tick();
    bus_gnt_i = 1'b0;
    check("pre_rst_busy", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    model_rdata = 32'd0;
    check("rst_mid_busy", 32'(busy_o), 32'd0);
    check("rst_mid_req", 32'(bus_req_o), 32'd0);
    check("rst_mid_done", 32'(done_o), 32'd0);
    repeat (2) tick();

    // LHU at 0x2 takes the upper half unsigned
    model_rdata = 32'h0000_BEEF; push(1'b0, 32'd0, 32'd0);
    issue(MEM_LHU, 32'h0000_0002, 32'd0);
    bus_resp(0, 1'b0, 32'hBEEF_0000, 32'h0000_0000, 4'b1100, 32'd0, 1'b0);

    repeat (2) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
